// File: rtl/cache_miss_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_miss_ctrl_if
// Bundles every signal between the cache miss controller and its neighbours:
// the CPU memory stage, the cache datapath and the main-memory block port.
//   master : the controller's view (drives stall, cache strobes, memory request,
//            refill data, performance counters and the error flag)
//   slave  : the environment's view (CPU request, cache status, memory response)
// ---------------------------------------------------------------------------
interface cache_miss_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 128,
  parameter int CNT_W  = 16
);
  // CPU side
  logic              cpu_rd_en;
  logic              cpu_wr_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic              stall;
  // Cache datapath side
  logic              cache_rd_en;
  logic              cache_wr_en;
  logic              cache_hit;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [BLK_W-1:0]  wb_data;
  logic              fetch_enable;
  logic [BLK_W-1:0]  fetch_data;
  // Main-memory block port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic              mem_ready;
  logic [BLK_W-1:0]  mem_rdata;
  // Status
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic              err;

  modport master (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cache_hit, wb_valid, wb_addr, wb_data,
           mem_ready, mem_rdata,
    output stall, cache_rd_en, cache_wr_en, fetch_enable, fetch_data,
           mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt, err
  );

  modport slave (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cache_hit, wb_valid, wb_addr, wb_data,
           mem_ready, mem_rdata,
    input  stall, cache_rd_en, cache_wr_en, fetch_enable, fetch_data,
           mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt, err
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// cache_miss_ctrl
// Sequences a 2-set data cache against main memory for one CPU load/store port.
// A CPU access is probed in the cache while the CPU is stalled; a miss runs an
// optional dirty-block write-back followed by a block refill, then the access
// is replayed into the cache. Saturating hit/miss counters and a sticky memory
// timeout flag are provided.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - cache_miss_ctrl_if.master (CPU, cache and memory signals)
// ---------------------------------------------------------------------------
module cache_miss_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 128,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_miss_ctrl_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  // Clears the byte-in-block offset so memory always sees block-aligned addresses
  localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-4){1'b1}}, 4'h0};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_REFILL = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [BLK_W-1:0]  fetch_data_q, fetch_data_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic stall_s, cache_rd_s, cache_wr_s, mem_req_s, mem_we_s, fetch_en_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fetch_data_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_data_q <= fetch_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fetch_data_d = fetch_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
    stall_s      = 1'b0;
    cache_rd_s   = 1'b0;
    cache_wr_s   = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    fetch_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_rd_en || bus.cpu_wr_en) begin
          // A store wins when both requests are raised together
          stall_s    = 1'b1;
          wr_d       = bus.cpu_wr_en;
          addr_d     = bus.cpu_addr;
          cache_wr_s = bus.cpu_wr_en;
          cache_rd_s = ~bus.cpu_wr_en;
          state_d    = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        stall_s = 1'b1;
        tmo_d   = '0;
        if (bus.cache_hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = S_DONE;
        end else if (bus.wb_valid) begin
          miss_cnt_d  = sat_inc(miss_cnt_q);
          mem_addr_d  = bus.wb_addr & BLK_MASK;
          mem_wdata_d = bus.wb_data;
          state_d     = S_WB;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          mem_addr_d = addr_q & BLK_MASK;
          state_d    = S_FILL;
        end
      end
      S_WB: begin
        stall_s   = 1'b1;
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        if (bus.mem_ready) begin
          // Refill request follows immediately, counter restarts for it
          tmo_d      = '0;
          mem_addr_d = addr_q & BLK_MASK;
          state_d    = S_FILL;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_FILL: begin
        stall_s   = 1'b1;
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          fetch_data_d = bus.mem_rdata;
          state_d      = S_REFILL;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_REFILL: begin
        // Replaying the original strobe lets a store merge its data into the new block
        stall_s    = 1'b1;
        fetch_en_s = 1'b1;
        cache_wr_s = wr_q;
        cache_rd_s = ~wr_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.stall        = stall_s;
  assign bus.cache_rd_en  = cache_rd_s;
  assign bus.cache_wr_en  = cache_wr_s;
  assign bus.fetch_enable = fetch_en_s;
  assign bus.fetch_data   = fetch_data_q;
  assign bus.mem_req      = mem_req_s;
  assign bus.mem_we       = mem_we_s;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.hit_cnt      = hit_cnt_q;
  assign bus.miss_cnt     = miss_cnt_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_miss_ctrl
// Self-checking bench for cache_miss_ctrl. The bench plays the cache datapath
// and main memory; a transaction-level model predicts stall length, memory
// transactions, refill, strobes, counters and the error flag for each access.
// ---------------------------------------------------------------------------
module tb_cache_miss_ctrl;
  localparam int ADDR_W  = 32;
  localparam int BLK_W   = 128;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .CNT_W(CNT_W)) bus ();

  cache_miss_ctrl #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [127:0] data;} txn_t;

  int vectors = 0;
  int errors  = 0;

  // observations of the last access
  txn_t obs_q[$];
  int obs_stall, obs_rd, obs_wr, obs_fe, obs_req;
  logic [127:0] obs_fdata;
  logic obs_req_done;
  // model expectations and state
  txn_t exp_q[$];
  int exp_stall, exp_rd, exp_wr, exp_fe, exp_req;
  int m_hit, m_miss;
  bit m_err;

  function automatic int lim(input int l);
    return (l > TIMEOUT) ? TIMEOUT : l;
  endfunction

  // Transaction-level prediction of one access
  task automatic model_access(input bit wr, input logic [31:0] addr, input bit hit, input bit wbv,
                              input logic [31:0] wba, input logic [127:0] wbd, input int lw, input int lf);
    bit wb_to, f_to;
    txn_t t;
    wb_to = 1'b0; f_to = 1'b0;
    exp_q.delete(); exp_stall = 2; exp_req = 0; exp_fe = 0;
    if (hit) begin
      m_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
    end else begin
      m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
      if (wbv) begin
        wb_to = lw > TIMEOUT;
        exp_stall += lim(lw); exp_req += lim(lw);
        if (!wb_to) begin t.we = 1'b1; t.addr = {wba[31:4], 4'h0}; t.data = wbd; exp_q.push_back(t); end
      end
      if (!wb_to) begin
        f_to = lf > TIMEOUT;
        exp_stall += lim(lf); exp_req += lim(lf);
        if (!f_to) begin
          t.we = 1'b0; t.addr = {addr[31:4], 4'h0}; t.data = 128'h0; exp_q.push_back(t);
          exp_stall += 1; exp_fe = 1;
        end
      end
      if (wb_to || f_to) m_err = 1'b1;
    end
    exp_wr = wr ? 1 + exp_fe : 0;
    exp_rd = wr ? 0 : 1 + exp_fe;
  endtask

  // Drives one CPU access, acts as cache/memory, records what the DUT did
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr, input bit hit,
                            input bit wbv, input logic [31:0] wba, input logic [127:0] wbd,
                            input int lw, input int lf, input logic [127:0] rdata, input bit scramble);
    int in_txn;
    bit done;
    txn_t t;
    obs_q.delete(); obs_stall = 0; obs_rd = 0; obs_wr = 0; obs_fe = 0; obs_req = 0;
    obs_fdata = 128'h0; obs_req_done = 1'b0; in_txn = 0; done = 1'b0;
    @(negedge clk);
    bus.cpu_rd_en = rd; bus.cpu_wr_en = wr; bus.cpu_addr = addr;
    bus.cache_hit = hit; bus.wb_valid = wbv; bus.wb_addr = wba; bus.wb_data = wbd;
    bus.mem_rdata = rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!bus.stall) begin
        done = 1'b1;
        obs_req_done = bus.mem_req;
      end else begin
        obs_stall++;
        if (bus.cache_rd_en) obs_rd++;
        if (bus.cache_wr_en) obs_wr++;
        if (bus.fetch_enable) begin obs_fe++; obs_fdata = bus.fetch_data; end
        if (bus.mem_req) begin
          obs_req++; in_txn++;
          if (in_txn == (bus.mem_we ? lw : lf)) begin
            bus.mem_ready = 1'b1;
            t.we = bus.mem_we; t.addr = bus.mem_addr; t.data = bus.mem_we ? bus.mem_wdata : 128'h0;
            obs_q.push_back(t);
            in_txn = 0;
          end else begin
            bus.mem_ready = 1'b0;
          end
        end else begin
          in_txn = 0;
          bus.mem_ready = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (scramble && c > 0) begin
          bus.cpu_addr = $urandom;
          bus.cpu_rd_en = 1'($urandom_range(0, 1));
          bus.cpu_wr_en = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
    end
    vectors++;
    if (!done) begin errors++; $display("FAIL access_bound: stall still %0d after 40 cycles, required 0", bus.stall); end
    bus.mem_ready = 1'b0; bus.cpu_rd_en = 1'b0; bus.cpu_wr_en = 1'b0;
  endtask

  task automatic test_reset;
    bus.cpu_rd_en = 1'b0; bus.cpu_wr_en = 1'b0; bus.cpu_addr = 32'h0;
    bus.cache_hit = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = 32'h0; bus.wb_data = 128'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 128'h0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if ({bus.stall, bus.cache_rd_en, bus.cache_wr_en, bus.fetch_enable} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b required 0000", {bus.stall, bus.cache_rd_en, bus.cache_wr_en, bus.fetch_enable}); end
    vectors++; if ({bus.mem_req, bus.mem_we, bus.err} !== 3'b000) begin
      errors++; $display("FAIL reset_mem: got %b required 000", {bus.mem_req, bus.mem_we, bus.err}); end
    vectors++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 128'h0 || bus.fetch_data !== 128'h0) begin
      errors++; $display("FAIL reset_data: got addr %0h wdata %0h fdata %0h required 0", bus.mem_addr, bus.mem_wdata, bus.fetch_data); end
    vectors++; if (bus.hit_cnt !== 4'h0 || bus.miss_cnt !== 4'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", bus.hit_cnt, bus.miss_cnt); end
    rst_n = 1'b1;
    m_hit = 0; m_miss = 0; m_err = 1'b0;
  endtask

  task automatic test_read_hit;
    model_access(1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1);
    run_access(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1, 128'h0, 1'b0);
    vectors++; if (obs_stall !== 2) begin errors++; $display("FAIL hit_stall: got %0d required 2", obs_stall); end
    vectors++; if (obs_req !== 0) begin errors++; $display("FAIL hit_no_mem: got %0d required 0", obs_req); end
    vectors++; if (bus.hit_cnt !== 4'd1) begin errors++; $display("FAIL hit_cnt: got %0d required 1", bus.hit_cnt); end
    vectors++; if (obs_rd !== 1 || obs_wr !== 0) begin errors++; $display("FAIL hit_strobe: got rd %0d wr %0d required 1/0", obs_rd, obs_wr); end
  endtask

  task automatic test_clean_miss;
    logic [127:0] blk;
    blk = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    model_access(1'b0, 32'h2000, 1'b0, 1'b0, 32'h0, 128'h0, 1, 3);
    run_access(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h0, 128'h0, 1, 3, blk, 1'b0);
    vectors++; if (obs_q.size() !== 1) begin errors++; $display("FAIL clean_txn_count: got %0d required 1", obs_q.size()); end
    else begin
      vectors++; if (obs_q[0].we !== 1'b0 || obs_q[0].addr !== 32'h2000) begin
        errors++; $display("FAIL clean_txn: got we %0b addr %0h required 0/2000", obs_q[0].we, obs_q[0].addr); end
    end
    vectors++; if (obs_fe !== 1 || obs_fdata !== blk) begin errors++; $display("FAIL clean_fetch: got %0d x %0h required 1 x %0h", obs_fe, obs_fdata, blk); end
    vectors++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL clean_stall: got %0d required %0d", obs_stall, exp_stall); end
    vectors++; if (bus.miss_cnt !== 4'd1) begin errors++; $display("FAIL clean_miss_cnt: got %0d required 1", bus.miss_cnt); end
    vectors++; if (obs_rd !== 2) begin errors++; $display("FAIL clean_rd_strobes: got %0d required 2", obs_rd); end
  endtask

  task automatic test_dirty_miss;
    logic [127:0] vd;
    vd = {$urandom, $urandom, $urandom, $urandom};
    model_access(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1);
    run_access(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1, 128'h0, 1'b0);
    vectors++; if (obs_wr !== 1 || obs_rd !== 0) begin errors++; $display("FAIL store_strobe: got wr %0d rd %0d required 1/0", obs_wr, obs_rd); end
    model_access(1'b0, 32'h4010, 1'b0, 1'b1, 32'h10, vd, 2, 3);
    run_access(1'b1, 1'b0, 32'h4010, 1'b0, 1'b1, 32'h10, vd, 2, 3, 128'h1234, 1'b0);
    vectors++; if (obs_q.size() !== 2) begin errors++; $display("FAIL dirty_txn_count: got %0d required 2", obs_q.size()); end
    else begin
      vectors++; if (obs_q[0].we !== 1'b1 || obs_q[0].addr !== 32'h10 || obs_q[0].data !== vd) begin
        errors++; $display("FAIL dirty_wb: got we %0b addr %0h data %0h required 1/10/%0h", obs_q[0].we, obs_q[0].addr, obs_q[0].data, vd); end
      vectors++; if (obs_q[1].we !== 1'b0 || obs_q[1].addr !== 32'h4010) begin
        errors++; $display("FAIL dirty_fill: got we %0b addr %0h required 0/4010", obs_q[1].we, obs_q[1].addr); end
    end
    vectors++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL dirty_stall: got %0d required %0d", obs_stall, exp_stall); end
  endtask

  task automatic test_both_en;
    model_access(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1);
    run_access(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1, 128'h0, 1'b0);
    vectors++; if (obs_wr !== 1 || obs_rd !== 0) begin errors++; $display("FAIL both_en: got wr %0d rd %0d required 1/0", obs_wr, obs_rd); end
    vectors++; if (bus.hit_cnt !== 4'(m_hit)) begin errors++; $display("FAIL both_hit_cnt: got %0d required %0d", bus.hit_cnt, m_hit); end
  endtask

  task automatic test_timeout;
    model_access(1'b0, 32'h3000, 1'b0, 1'b0, 32'h0, 128'h0, 1, TIMEOUT + 1);
    run_access(1'b1, 1'b0, 32'h3000, 1'b0, 1'b0, 32'h0, 128'h0, 1, TIMEOUT + 1, 128'h0, 1'b0);
    vectors++; if (bus.err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0b required 1", bus.err); end
    vectors++; if (obs_req !== TIMEOUT) begin errors++; $display("FAIL tmo_req_cycles: got %0d required %0d", obs_req, TIMEOUT); end
    vectors++; if (obs_req_done !== 1'b0) begin errors++; $display("FAIL tmo_req_drop: got %0b required 0", obs_req_done); end
    vectors++; if (obs_fe !== 0 || obs_stall !== 2 + TIMEOUT) begin
      errors++; $display("FAIL tmo_abandon: got fe %0d stall %0d required 0/%0d", obs_fe, obs_stall, 2 + TIMEOUT); end
  endtask

  task automatic test_reset_in_wb;
    bit found;
    found = 1'b0;
    @(negedge clk);
    bus.cpu_rd_en = 1'b1; bus.cpu_addr = 32'h4010; bus.cache_hit = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 32'h30; bus.mem_ready = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (bus.mem_req && bus.mem_we) found = 1'b1;
      else @(negedge clk);
    end
    vectors++; if (!found) begin errors++; $display("FAIL rstwb_reach: got no write-back in 10 cycles, required one"); end
    bus.cpu_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL rstwb_async: got req %0b stall %0b required 0/0", bus.mem_req, bus.stall); end
    vectors++; if (bus.hit_cnt !== 4'h0 || bus.miss_cnt !== 4'h0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL rstwb_clear: got %0d/%0d/%0b required 0/0/0", bus.hit_cnt, bus.miss_cnt, bus.err); end
    @(negedge clk);
    rst_n = 1'b1;
    m_hit = 0; m_miss = 0; m_err = 1'b0;
  endtask

  task automatic test_random;
    bit rd, wr, hit, wbv;
    int op, lw, lf;
    logic [31:0] addr, wba;
    logic [127:0] wbd, rdata;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2); rd = (op != 1); wr = (op != 0);
      addr = $urandom; wba = $urandom;
      hit = 1'($urandom_range(0, 1)); wbv = 1'($urandom_range(0, 1));
      wbd = {$urandom, $urandom, $urandom, $urandom};
      rdata = {$urandom, $urandom, $urandom, $urandom};
      lw = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, TIMEOUT));
      lf = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, TIMEOUT));
      model_access(wr, addr, hit, wbv, wba, wbd, lw, lf);
      run_access(rd, wr, addr, hit, wbv, wba, wbd, lw, lf, rdata, 1'b1);
      vectors++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd%0d_stall: got %0d required %0d", n, obs_stall, exp_stall); end
      vectors++; if (obs_rd !== exp_rd || obs_wr !== exp_wr) begin
        errors++; $display("FAIL rnd%0d_strobes: got %0d/%0d required %0d/%0d", n, obs_rd, obs_wr, exp_rd, exp_wr); end
      vectors++; if (obs_req !== exp_req || obs_req_done !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_req: got %0d/%0b required %0d/0", n, obs_req, obs_req_done, exp_req); end
      vectors++; if (obs_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_txn_count: got %0d required %0d", n, obs_q.size(), exp_q.size()); end
      else begin
        for (int k = 0; k < obs_q.size(); k++) begin
          vectors++; if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL rnd%0d_txn%0d: got %0b/%0h/%0h required %0b/%0h/%0h", n, k,
              obs_q[k].we, obs_q[k].addr, obs_q[k].data, exp_q[k].we, exp_q[k].addr, exp_q[k].data); end
        end
      end
      vectors++; if (obs_fe !== exp_fe || (exp_fe == 1 && obs_fdata !== rdata)) begin
        errors++; $display("FAIL rnd%0d_fetch: got %0d x %0h required %0d x %0h", n, obs_fe, obs_fdata, exp_fe, rdata); end
      vectors++; if (bus.hit_cnt !== 4'(m_hit) || bus.miss_cnt !== 4'(m_miss) || bus.err !== m_err) begin
        errors++; $display("FAIL rnd%0d_status: got %0d/%0d/%0b required %0d/%0d/%0b", n, bus.hit_cnt, bus.miss_cnt, bus.err, m_hit, m_miss, m_err); end
    end
  endtask

  task automatic test_saturation;
    for (int n = 0; n < CMAX + 3; n++) begin
      model_access(1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1);
      run_access(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 128'h0, 1, 1, 128'h0, 1'b0);
      model_access(1'b0, 32'h800, 1'b0, 1'b0, 32'h0, 128'h0, 1, 1);
      run_access(1'b1, 1'b0, 32'h800, 1'b0, 1'b0, 32'h0, 128'h0, 1, 1, 128'h55, 1'b0);
    end
    vectors++; if (bus.hit_cnt !== 4'(CMAX) || bus.hit_cnt !== 4'(m_hit)) begin
      errors++; $display("FAIL sat_hit: got %0d required %0d", bus.hit_cnt, CMAX); end
    vectors++; if (bus.miss_cnt !== 4'(CMAX) || bus.miss_cnt !== 4'(m_miss)) begin
      errors++; $display("FAIL sat_miss: got %0d required %0d", bus.miss_cnt, CMAX); end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_clean_miss();
    test_dirty_miss();
    test_both_en();
    test_timeout();
    test_reset_in_wb();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
